// File: rtl/ps2_scancode_fifo_if.sv
// ps2_scancode_fifo_if: byte-in / event-out handshake between PS/2 receiver, decoder FIFO and bus side
interface ps2_scancode_fifo_if #(parameter int ADDR_W = 4);
  logic [7:0] data_in;
  logic data_valid;
  logic rd_en;
  logic clr_overflow;
  logic [9:0] rd_data;
  logic empty;
  logic full;
  logic [ADDR_W:0] count;
  logic overflow;
  modport master (output data_in, data_valid, rd_en, clr_overflow,
                  input rd_data, empty, full, count, overflow);
  modport slave (input data_in, data_valid, rd_en, clr_overflow,
                 output rd_data, empty, full, count, overflow);
endinterface

// File: rtl/ps2_scancode_fifo.sv
// ps2_scancode_fifo: folds Set-2 prefix bytes into {break, extended, code} events and buffers them in a FWFT FIFO
module ps2_scancode_fifo #(
  parameter int DEPTH = 16,
  parameter int ADDR_W = 4
) (
  input logic clk,
  input logic reset,
  ps2_scancode_fifo_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0, EXT = 3'd1, BRK = 3'd2, EXT_BRK = 3'd3, PAUSE = 3'd4;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  logic [2:0] state, state_nxt, pcnt, pcnt_nxt;
  logic [7:0] b;
  logic push, do_push, do_pop, drop, ovf;
  logic [9:0] word;
  logic [9:0] mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr, wr_ptr;
  logic [ADDR_W:0] cnt;
  assign b = bus.data_in;
  always_comb begin
    state_nxt = state;
    pcnt_nxt = pcnt;
    push = 1'b0;
    word = {2'b00, b};
    if (bus.data_valid)
      case (state)
        IDLE:
          if (b == 8'hE0) state_nxt = EXT;
          else if (b == 8'hF0) state_nxt = BRK;
          else if (b == 8'hE1) begin
            state_nxt = PAUSE;
            pcnt_nxt = 3'd7;
          end else push = !(b inside {8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF});
        EXT:
          if (b == 8'hF0) state_nxt = EXT_BRK;
          else if (b != 8'hE0) begin
            push = 1'b1;
            word = {2'b01, b};
            state_nxt = IDLE;
          end
        BRK:
          if (b == 8'hE0) state_nxt = EXT_BRK;
          else if (b != 8'hF0) begin
            push = 1'b1;
            word = {2'b10, b};
            state_nxt = IDLE;
          end
        EXT_BRK:
          if (b != 8'hE0 && b != 8'hF0) begin
            push = 1'b1;
            word = {2'b11, b};
            state_nxt = IDLE;
          end
        PAUSE: begin
          pcnt_nxt = pcnt - 3'd1;
          if (pcnt == 3'd1) begin
            push = 1'b1;
            word = {2'b01, 8'hE1};
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
  end
  assign bus.empty = cnt == '0;
  assign bus.full = cnt == FULL_CNT;
  assign bus.count = cnt;
  assign bus.overflow = ovf;
  assign bus.rd_data = mem[rd_ptr];
  // a pop frees the slot on the same edge, so a full FIFO still accepts the push
  assign do_pop = bus.rd_en && !bus.empty;
  assign do_push = push && (!bus.full || do_pop);
  assign drop = push && bus.full && !do_pop;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      pcnt <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_nxt;
      pcnt <= pcnt_nxt;
      if (do_push) begin
        mem[wr_ptr] <= word;
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + ADDR_W'(1);
      cnt <= (do_push && !do_pop) ? cnt + (ADDR_W+1)'(1) :
             (do_pop && !do_push) ? cnt - (ADDR_W+1)'(1) : cnt;
      ovf <= drop ? 1'b1 : bus.clr_overflow ? 1'b0 : ovf;
    end
endmodule

// File: tb/tb_ps2_scancode_fifo.sv
// tb_ps2_scancode_fifo: vector table, corner sequences and random traffic against a queue-based model
module tb_ps2_scancode_fifo;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  ps2_scancode_fifo_if #(.ADDR_W(4)) bus();
  ps2_scancode_fifo #(.DEPTH(DEPTH), .ADDR_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic [9:0] q[$];
  bit m_ext, m_brk, m_ov;
  int m_pend;
  typedef struct {
    bit dv;
    logic [7:0] b;
    bit rd;
    logic [4:0] cnt;
    logic [9:0] head;
  } vec_t;
  vec_t tv [26];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic void model_reset();
    q.delete();
    m_ext = 0;
    m_brk = 0;
    m_ov = 0;
    m_pend = 0;
  endfunction
  // key-event rules expressed as prefix flags plus a remaining-pause-byte count
  function automatic void model_byte(input logic [7:0] b, output bit ev, output logic [9:0] w);
    ev = 0;
    w = '0;
    if (m_pend > 0) begin
      m_pend--;
      if (m_pend == 0) begin
        ev = 1;
        w = 10'h1E1;
      end
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (!m_ext && !m_brk) begin
      if (b == 8'hE1) m_pend = 7;
      else if (!(b inside {8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF})) begin
        ev = 1;
        w = {2'b00, b};
      end
    end else begin
      ev = 1;
      w = {m_brk, m_ext, b};
      m_ext = 0;
      m_brk = 0;
    end
  endfunction
  task automatic compare_model();
    chk("count", bus.count, q.size());
    chk("empty", bus.empty, q.size() == 0);
    chk("full", bus.full, q.size() == DEPTH);
    chk("overflow", bus.overflow, m_ov);
    if (q.size() > 0) chk("rd_data", bus.rd_data, q[0]);
  endtask
  task automatic step(input bit dv, input logic [7:0] b, input bit rd, input bit clr);
    bit ev, drop;
    logic [9:0] w;
    bus.data_valid = dv;
    bus.data_in = b;
    bus.rd_en = rd;
    bus.clr_overflow = clr;
    @(posedge clk);
    ev = 0;
    w = '0;
    if (dv) model_byte(b, ev, w);
    if (rd && q.size() > 0) void'(q.pop_front());
    drop = ev && q.size() >= DEPTH;
    if (ev && !drop) q.push_back(w);
    m_ov = drop ? 1'b1 : clr ? 1'b0 : m_ov;
    #1;
    compare_model();
    bus.data_valid = 0;
    bus.rd_en = 0;
    bus.clr_overflow = 0;
  endtask
  initial begin
    logic [7:0] rb;
    int r;
    tv = '{
      '{1, 8'h1C, 0, 5'd1, 10'h01C}, '{0, 8'h00, 0, 5'd1, 10'h01C},
      '{1, 8'hF0, 0, 5'd1, 10'h01C}, '{1, 8'h1C, 0, 5'd2, 10'h01C},
      '{0, 8'h00, 1, 5'd1, 10'h21C}, '{1, 8'hE0, 0, 5'd1, 10'h21C},
      '{1, 8'h75, 0, 5'd2, 10'h21C}, '{0, 8'h00, 1, 5'd1, 10'h175},
      '{1, 8'hE0, 0, 5'd1, 10'h175}, '{1, 8'hF0, 0, 5'd1, 10'h175},
      '{1, 8'h75, 0, 5'd2, 10'h175}, '{1, 8'hAA, 0, 5'd2, 10'h175},
      '{1, 8'hFA, 0, 5'd2, 10'h175}, '{0, 8'h00, 1, 5'd1, 10'h375},
      '{0, 8'h00, 1, 5'd0, 10'h000}, '{1, 8'hE1, 0, 5'd0, 10'h000},
      '{1, 8'h14, 0, 5'd0, 10'h000}, '{1, 8'h77, 0, 5'd0, 10'h000},
      '{1, 8'hE1, 0, 5'd0, 10'h000}, '{1, 8'hF0, 0, 5'd0, 10'h000},
      '{1, 8'h14, 0, 5'd0, 10'h000}, '{1, 8'hF0, 0, 5'd0, 10'h000},
      '{1, 8'h77, 0, 5'd1, 10'h1E1}, '{1, 8'h1C, 0, 5'd2, 10'h1E1},
      '{0, 8'h00, 1, 5'd1, 10'h01C}, '{0, 8'h00, 1, 5'd0, 10'h000}};
    bus.data_valid = 0;
    bus.data_in = '0;
    bus.rd_en = 0;
    bus.clr_overflow = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    reset = 0;
    for (int i = 0; i < 26; i++) begin
      step(tv[i].dv, tv[i].b, tv[i].rd, 0);
      chk("vec_count", bus.count, tv[i].cnt);
      if (tv[i].cnt != 0) chk("vec_head", bus.rd_data, tv[i].head);
    end
    for (int i = 1; i <= DEPTH; i++) step(1, 8'(i), 0, 0);
    chk("fill_full", bus.full, 1);
    chk("fill_count", bus.count, DEPTH);
    step(1, 8'h11, 0, 0);
    chk("drop_overflow", bus.overflow, 1);
    chk("drop_count", bus.count, DEPTH);
    step(0, 8'h00, 0, 1);
    chk("clr_overflow", bus.overflow, 0);
    step(1, 8'h22, 1, 0);
    chk("full_pushpop_count", bus.count, DEPTH);
    chk("full_pushpop_ovf", bus.overflow, 0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_order", bus.rd_data, (i < DEPTH - 1) ? 10'h002 + 10'(i) : 10'h022);
      step(0, 8'h00, 1, 0);
    end
    chk("drain_empty", bus.empty, 1);
    step(1, 8'h33, 1, 0);
    chk("empty_pushpop_count", bus.count, 1);
    chk("empty_pushpop_data", bus.rd_data, 10'h033);
    step(0, 8'h00, 1, 0);
    for (int i = 0; i < DEPTH; i++) step(1, 8'h40 + 8'(i), 0, 0);
    step(1, 8'h55, 0, 1);
    chk("set_wins_overflow", bus.overflow, 1);
    step(0, 8'h00, 0, 1);
    for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1, 0);
    step(1, 8'h1C, 0, 0);
    step(1, 8'hF0, 0, 0);
    #2 reset = 1;
    #1;
    chk("midrst_count", bus.count, 0);
    chk("midrst_empty", bus.empty, 1);
    chk("midrst_full", bus.full, 0);
    chk("midrst_overflow", bus.overflow, 0);
    chk("midrst_rd_data", bus.rd_data, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    step(1, 8'h1C, 0, 0);
    chk("after_rst_event", bus.rd_data, 10'h01C);
    step(0, 8'h00, 1, 0);
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 9);
      rb = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : (r == 2) ? 8'hE1 :
           (r == 3) ? 8'hAA : (r == 4) ? 8'h00 : 8'($urandom_range(0, 255));
      step($urandom_range(0, 9) < 6, rb, $urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_scancode_fifo.md
Name: ps2_scancode_fifo

Overview:
- Consumes the byte stream from the PS/2 keyboard receiver: an 8-bit scancode plus a one-clk ready pulse per byte.
- Folds Set-2 prefix bytes (E0 extended, F0 break, E1 pause) into single key-event words.
- Buffers the events in a first-word-fall-through FIFO that the CPU bus side pops.
- Sits between the keyboard device and the memory-mapped keyboard register.

Parameters:
DEPTH, 16, FIFO entries; power of two, at least 2
ADDR_W, 4, log2(DEPTH)

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  asynchronous, active-high reset
data_in  input  8  scancode byte from receiver; sampled only when data_valid=1
data_valid  input  1  one-clk pulse per received byte
rd_en  input  1  pop request from bus side
clr_overflow  input  1  clears the sticky overflow flag
rd_data  output  10  {break, extended, code[7:0]} at head of FIFO
empty  output  1  FIFO holds no events
full  output  1  FIFO holds DEPTH events
count  output  ADDR_W+1  number of stored events, 0..DEPTH
overflow  output  1  sticky; an event was dropped

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Reset values: state=IDLE, rd/wr pointers=0, count=0, empty=1, full=0, overflow=0, pause counter=0, all memory words=0, rd_data=0.
- Reset mid-sequence discards any partial prefix.
- Decoder FSM: advances only on clk edges with data_valid=1. Bytes arriving in the same cycle as reset deassertion are processed normally.
- IDLE, byte E0 -> EXT.
- IDLE, byte F0 -> BRK.
- IDLE, byte E1 -> PAUSE, pause counter=7.
- IDLE, byte in {00, AA, FA, FE, FF} -> ignored, stay IDLE.
- IDLE, any other byte -> push {0,0,byte}, stay IDLE.
- EXT: F0 -> EXT_BRK; E0 -> ignored, stay EXT; any other byte -> push {0,1,byte}, go IDLE.
- BRK: F0 -> ignored, stay BRK; E0 -> EXT_BRK; any other byte -> push {1,0,byte}, go IDLE.
- EXT_BRK: E0/F0 -> ignored, stay; any other byte -> push {1,1,byte}, go IDLE.
- PAUSE: every byte decrements the counter. When the counter goes 1->0, push {0,1,E1} and go IDLE. No other bytes of the 8-byte pause sequence are pushed.
- Push timing: the event is written on the same edge the completing byte is sampled. empty deasserts and count increments on that edge, so the event is visible on rd_data the next cycle.
- FIFO is first-word-fall-through: rd_data = mem[rd_ptr], combinational from storage. rd_data is valid whenever empty=0.
- Pop: rd_en=1 and empty=0 at an edge advances rd_ptr and decrements count. rd_en while empty is ignored; no underflow, rd_data unchanged.
- Pointers are ADDR_W bits and wrap modulo DEPTH.
- count is a separate up/down counter. empty = (count==0); full = (count==DEPTH).
- Push with pop, FIFO full: both occur, count stays DEPTH, no overflow.
- Push with pop, FIFO empty: pop ignored, push accepted, count becomes 1.
- Push while full with no pop: event dropped, pointers and count unchanged, overflow set to 1.
- overflow clears only on clr_overflow=1. If clr_overflow and a new drop occur in the same cycle, set wins.
- Latency: completing byte sampled at edge N -> event readable on rd_data after edge N.

Test Plan:
- Reset, then bytes 1C; F0 1C (one data_valid pulse each, 3+ idle clks between) -> two events, 0x01C then 0x21C. count=2 one cycle after the last pulse.
- Bytes E0 75 then E0 F0 75 -> events 0x175 then 0x375. Bytes AA and FA sent in IDLE -> nothing pushed, count unchanged.
- Pause sequence E1 14 77 E1 F0 14 F0 77 -> exactly one event 0x1E1. Next byte 1C -> event 0x01C; state is back to IDLE.
- Fill 16 make codes 01..10 with no pops -> full=1, count=16. 17th byte 11 -> dropped, overflow=1. Pop all -> rd_data sequence 0x001..0x010, empty=1. Pulse clr_overflow -> overflow=0.
- Full FIFO, data_valid (byte 22) and rd_en in the same cycle -> count stays 16, overflow=0, byte 22 is the newest entry. Empty FIFO with rd_en and a push in the same cycle -> count=1, rd_data = pushed event.
- Send F0 and assert reset before the next byte. Release reset, then send 1C -> event 0x01C (make, not break); all outputs at reset values during reset.
